seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised multi-cycle integer multiplier for the RV32M/RV64M execute stage. Supersedes the single-cycle combinational multiplier.
- Computes the full 2*XLEN-bit product of two XLEN-bit operands in all four RISC-V signedness modes, STEP bits per cycle.
- Uses a start/busy/done handshake so the core can stall on long-latency M-extension ops.
- Supports abort through a kill input.

Parameters:
- XLEN, 32, operand width; legal values 32 or 64.
- STEP, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8; must divide XLEN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a new multiply; accepted only in IDLE.
- kill  in  1  abort the operation in flight (pipeline flush).
- op  in  2  00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u).
- rs1  in  XLEN  multiplicand; signed when op is 01 or 10.
- rs2  in  XLEN  multiplier; signed when op is 01.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result, high and low are valid.
- result  out  XLEN  low when op=00, otherwise high.
- high  out  XLEN  product bits [2*XLEN-1:XLEN].
- low  out  XLEN  product bits [XLEN-1:0].

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: rst_n=0 at a clock edge forces state IDLE and clears busy, done, result, high, low and all internal registers to 0. Reset mid-operation discards the operation and produces no done pulse.
- FSM states and transitions:
  - IDLE: start=1 latches op, rs1 and rs2, then moves to PREP. start while not in IDLE is ignored.
  - PREP: takes operand magnitudes, with abs(-2^(XLEN-1)) = 2^(XLEN-1) as an unsigned XLEN-bit value. Records neg = sign(rs1 if signed) XOR sign(rs2 if signed). Clears the accumulator and loads the counter with XLEN/STEP. Moves to CALC.
  - CALC: each cycle, adds the shifted multiplicand times the low STEP bits of the multiplier into a 2*XLEN-bit accumulator, shifts, and decrements the counter. When the counter reaches 1, moves to FIX.
  - FIX: if neg, the product is the two's complement of the accumulator modulo 2^(2*XLEN); otherwise the accumulator. Registers high, low and result, pulses done for 1 cycle and returns to IDLE.
- Latency: start accepted at edge N gives done high in the cycle after edge N+2+XLEN/STEP. That is 35 cycles for XLEN=32, STEP=1 and 11 cycles for STEP=4.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted because the FSM is in IDLE at that edge, so there is no idle bubble required.
- Outputs: result, high and low hold their value after done until the next FIX. busy=1 in PREP, CALC and FIX; busy=0 in IDLE.
- Kill: kill=1 in any non-IDLE state returns the FSM to IDLE at that edge with no done pulse, and result, high and low are unchanged. kill takes priority over start. kill in IDLE is a no-op, and start is not accepted that cycle.
- Arithmetic: the product is exact over 2*XLEN bits. MULHSU treats rs2 as unsigned even when its MSB is set. MUL low bits are identical for every op.

Optional Feature:
- Macro: SEQ_MULT_ZERO_SKIP_EN.
- Defined: in PREP, if either magnitude is 0, the FSM skips CALC and goes straight to FIX with the accumulator at 0. done then comes 3 cycles after the start edge, and high, low and result are all 0.
- Not defined: latency is always the fixed figure in Behaviour, regardless of operand values.

Test Plan:
- Reset, then start with op=00, rs1=7, rs2=6 (XLEN=32, STEP=1) -> done exactly 35 cycles later; low=42, high=0, result=42; busy high for the 34 cycles before done.
- op=01, rs1=0x80000000, rs2=0x80000000 -> high=0x40000000, low=0, result=0x40000000.
- op=10, rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> high=0xFFFFFFFF, low=0x00000001. op=11 with the same operands -> high=0xFFFFFFFE, low=0x00000001.
- Start accepted, kill at CALC cycle 10 -> no done, busy=0 next cycle, outputs keep their previous values. A new start in the following cycle completes normally. Repeat the scenario with rst_n=0 mid-CALC -> all outputs 0.
- start held high during busy, then back-to-back start in the done cycle -> exactly two results, no dropped or duplicated done. With SEQ_MULT_ZERO_SKIP_EN, rs1=0 and rs2=0x1234 -> done after 3 cycles with result 0.
- STEP=4 build, 10,000 random op/rs1/rs2 triples -> result, high and low match a 64-bit signed/unsigned golden model; done latency is 11 cycles on every transaction.

Source files
------------

// File: rtl/seq_mult.sv
// Multi-cycle RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU), STEP multiplier bits per cycle.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: bypass CALC when either operand magnitude is zero.
module seq_mult #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] high,
    output logic [XLEN-1:0] low
);

    localparam int CNT_W = $clog2(XLEN / STEP + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e              state_q;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    logic                neg_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     high_q;
    logic [XLEN-1:0]     low_q;

    logic                sign1_d;
    logic                sign2_d;
    logic [XLEN-1:0]     mag1_d;
    logic [XLEN-1:0]     mag2_d;
    logic [XLEN+STEP-1:0] partial_d;
    logic [2*XLEN-1:0]   acc_step_d;
    logic [2*XLEN-1:0]   prod_d;

    // Operand magnitudes, one radix-2^STEP accumulate step, and final sign fix-up.
    always_comb begin
        sign1_d = rs1_q[XLEN-1] & ((op_q == 2'b01) | (op_q == 2'b10));
        sign2_d = rs2_q[XLEN-1] & (op_q == 2'b01);
        // Unsigned negation maps -2^(XLEN-1) onto 2^(XLEN-1), which fits as a magnitude.
        if (sign1_d) begin
            mag1_d = ~rs1_q + XLEN'(1);
        end else begin
            mag1_d = rs1_q;
        end
        if (sign2_d) begin
            mag2_d = ~rs2_q + XLEN'(1);
        end else begin
            mag2_d = rs2_q;
        end
        // Low half of acc_q holds the not-yet-retired multiplier bits; the sum cannot overflow XLEN+STEP.
        partial_d  = {{STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                   + ({{STEP{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[STEP-1:0]});
        acc_step_d = {partial_d, acc_q[XLEN-1:STEP]};
        if (neg_q) begin
            prod_d = ~acc_q + (2*XLEN)'(1);
        end else begin
            prod_d = acc_q;
        end
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            rs1_q    <= '0;
            rs2_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (kill && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !kill) begin
                            op_q    <= op;
                            rs1_q   <= rs1;
                            rs2_q   <= rs2;
                            busy_q  <= 1'b1;
                            state_q <= S_PREP;
                        end else begin
                            busy_q  <= 1'b0;
                        end
                    end
                    S_PREP: begin
                        mcand_q <= mag1_d;
                        acc_q   <= {{XLEN{1'b0}}, mag2_d};
                        neg_q   <= sign1_d ^ sign2_d;
                        cnt_q   <= CNT_INIT;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                        if ((mag1_d == '0) || (mag2_d == '0)) begin
                            acc_q   <= '0;
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                    S_CALC: begin
                        acc_q <= acc_step_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                    S_FIX: begin
                        high_q   <= prod_d[2*XLEN-1:XLEN];
                        low_q    <= prod_d[XLEN-1:0];
                        if (op_q == 2'b00) begin
                            result_q <= prod_d[XLEN-1:0];
                        end else begin
                            result_q <= prod_d[2*XLEN-1:XLEN];
                        end
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign high   = high_q;
    assign low    = low_q;

endmodule
